// File: rtl/approx_mult_trunc_pipe_if.sv
// approx_mult_trunc_pipe_if: operand/result valid-ready bus of the approximate multiplier
interface approx_mult_trunc_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z;
    logic                 z_mode;
    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, z, z_mode
    );
    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, z, z_mode
    );
endinterface

// File: rtl/approx_mult_trunc_pipe.sv
// approx_mult_trunc_pipe: pipelined unsigned multiplier with column-truncated approximate mode and mismatch counter
module approx_mult_trunc_pipe #(
    parameter int WIDTH  = 8,
    parameter int TRUNC  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    approx_mult_trunc_pipe_if.slave bus,
    input  logic                    cnt_clr_i,
    output logic [CNT_W-1:0]        err_cnt_o
);
    localparam int PW    = 2 * WIDTH;
    localparam int CHUNK = (STAGES == 1) ? WIDTH : (WIDTH + STAGES - 2) / (STAGES - 1);

    typedef struct packed {
        logic [WIDTH-1:0][PW-1:0] rows;
        logic [PW-1:0]            acc;
        logic [PW-1:0]            exact;
        logic                     mode;
    } beat_t;

    beat_t            gen;
    beat_t            src  [1:STAGES];
    beat_t            st_d [1:STAGES];
    beat_t            st_q [1:STAGES];
    logic [STAGES:1]  v_q;
    logic [STAGES:0]  vc;
    logic [STAGES:1]  en;
    logic [PW-1:0]    mask;
    logic [CNT_W-1:0] err_q, err_d;
    logic             in_fire, out_fire, mism;

    assign mask = bus.mode ? ({PW{1'b1}} << TRUNC) : {PW{1'b1}};

    always_comb begin
        gen       = '0;
        gen.mode  = bus.mode;
        gen.exact = PW'(bus.x) * PW'(bus.y);
        for (int j = 0; j < WIDTH; j++)
            gen.rows[j] = bus.y[j] ? (PW'(bus.x) << j) & mask : '0;
    end

    // A stage may load if it, or any stage after it, has a free slot this cycle.
    always_comb begin
        en = '0;
        for (int s = 1; s <= STAGES; s++)
            en[s] = bus.out_ready | (|(~v_q & ({STAGES{1'b1}} << (s - 1))));
    end

    assign in_fire      = bus.in_valid & bus.in_ready;
    assign bus.in_ready = rst_n & en[1];
    assign vc           = {v_q, in_fire};

    // Rows are summed in slices across the stages after generation (all in stage 1 when single-stage).
    always_comb begin
        src[1] = gen;
        for (int s = 2; s <= STAGES; s++)
            src[s] = st_q[s-1];
        for (int s = 1; s <= STAGES; s++) begin
            st_d[s] = src[s];
            for (int j = 0; j < WIDTH; j++)
                if (STAGES == 1 || j / CHUNK + 2 == s)
                    st_d[s].acc = st_d[s].acc + src[s].rows[j];
        end
    end

    assign bus.out_valid = v_q[STAGES];
    assign bus.z         = st_q[STAGES].acc;
    assign bus.z_mode    = st_q[STAGES].mode;
    assign out_fire      = v_q[STAGES] & bus.out_ready;
    assign mism          = st_q[STAGES].mode & (st_q[STAGES].acc != st_q[STAGES].exact);
    assign err_d         = cnt_clr_i ? '0 : (out_fire & mism & ~&err_q) ? err_q + CNT_W'(1) : err_q;
    assign err_cnt_o     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            err_q <= '0;
            for (int s = 1; s <= STAGES; s++)
                st_q[s] <= '0;
        end else begin
            err_q <= err_d;
            for (int s = 1; s <= STAGES; s++)
                if (en[s]) begin
                    v_q[s]  <= vc[s-1];
                    st_q[s] <= st_d[s];
                end
        end
    end
endmodule

// File: tb/tb_approx_mult_trunc_pipe.sv
// tb_approx_mult_trunc_pipe: scoreboard bench for the truncated approximate multiplier
module tb_approx_mult_trunc_pipe;
    localparam int W  = 8;
    localparam int T  = 8;
    localparam int S  = 2;
    localparam int ZW = 2 * W;

    typedef struct {
        logic [ZW-1:0] z;
        logic          m;
        logic [ZW-1:0] exact;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, clr_a = 1'b0, clr_b = 1'b0, rand_rdy = 1'b0;
    logic [15:0] err_a, err_exp = '0;
    logic [1:0]  err_b;
    logic [ZW-1:0] prev_z = '0;
    logic        prev_m = 1'b0;
    bit          prev_stall = 0, prev_rst = 0, mism;
    int          n_tests = 0, n_fail = 0, acc, nb;
    exp_t        q[$];
    exp_t        e_mon;

    approx_mult_trunc_pipe_if #(.WIDTH(W)) ifa ();
    approx_mult_trunc_pipe_if #(.WIDTH(W)) ifb ();

    approx_mult_trunc_pipe #(.WIDTH(W), .TRUNC(T), .STAGES(S), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .cnt_clr_i(clr_a), .err_cnt_o(err_a)
    );
    approx_mult_trunc_pipe #(.WIDTH(W), .TRUNC(T), .STAGES(S), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .cnt_clr_i(clr_b), .err_cnt_o(err_b)
    );

    always #5 clk = ~clk;

    function automatic logic [ZW-1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic m);
        logic [ZW-1:0] s = '0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (x[i] && y[j] && (!m || i + j >= T)) s += ZW'(1) << (i + j);
        return s;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [W-1:0] x, logic [W-1:0] y, logic m);
        exp_t e;
        e.z = model(x, y, m);
        e.m = m;
        e.exact = ZW'(x) * ZW'(y);
        q.push_back(e);
    endtask

    task automatic send_a(logic [W-1:0] x, logic [W-1:0] y, logic m);
        bit done = 0;
        ifa.in_valid = 1'b1;
        ifa.x = x;
        ifa.y = y;
        ifa.mode = m;
        for (int b = 0; b < 200 && !done; b++) begin
            @(negedge clk);
            if (ifa.in_ready) begin
                push(x, y, m);
                done = 1;
            end
            step;
        end
        check("send_accept", 32'(done), 1);
    endtask

    task automatic drain;
        for (int b = 0; b < 500 && q.size() != 0; b++) step;
        check("drain_empty", q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) ifa.out_ready = 1'($urandom);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            err_exp = '0;
            prev_stall = 0;
            prev_rst = 1;
        end else begin
            if (prev_rst) check("reset_out_valid", 32'(ifa.out_valid), 0);
            prev_rst = 0;
            check("err_cnt", err_a, err_exp);
            if (prev_stall) begin
                check("stall_valid", 32'(ifa.out_valid), 1);
                check("stall_z", ifa.z, prev_z);
                check("stall_mode", 32'(ifa.z_mode), 32'(prev_m));
            end
            mism = 0;
            if (ifa.out_valid && ifa.out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got z=%0d, expected no beat", ifa.z);
                end else begin
                    e_mon = q.pop_front();
                    check("z", ifa.z, e_mon.z);
                    check("z_mode", 32'(ifa.z_mode), 32'(e_mon.m));
                    mism = e_mon.m && (e_mon.z != e_mon.exact);
                end
            end
            if (clr_a) err_exp = '0;
            else if (mism && err_exp != 16'hFFFF) err_exp++;
            prev_stall = ifa.out_valid && !ifa.out_ready;
            prev_z = ifa.z;
            prev_m = ifa.z_mode;
        end
    end

    initial begin
        ifa.in_valid = 0; ifa.x = 0; ifa.y = 0; ifa.mode = 0; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.x = 0; ifb.y = 0; ifb.mode = 0; ifb.out_ready = 0;
        repeat (2) step;
        @(negedge clk);
        check("rst_in_ready", 32'(ifa.in_ready), 0);
        check("rst_out_valid", 32'(ifa.out_valid), 0);
        check("rst_z", ifa.z, 0);
        check("rst_z_mode", 32'(ifa.z_mode), 0);
        check("rst_err", err_a, 0);
        step;
        rst_n = 1;
        ifa.out_ready = 1;
        ifb.out_ready = 1;

        send_a(8'd255, 8'd255, 1'b0);
        ifa.in_valid = 0;
        @(negedge clk);
        check("lat_early", 32'(ifa.out_valid), 0);
        step;
        @(negedge clk);
        check("lat_valid", 32'(ifa.out_valid), 1);
        check("lat_z", ifa.z, 65025);
        step;
        send_a(8'd255, 8'd255, 1'b1);
        send_a(8'd15, 8'd15, 1'b1);
        send_a(8'd16, 8'd16, 1'b1);
        ifa.in_valid = 0;
        drain;
        @(negedge clk);
        check("err_directed", err_a, 2);
        step;

        rand_rdy = 1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ifa.in_valid = 0;
                step;
            end
            send_a(W'($urandom), W'($urandom), 1'($urandom));
        end
        ifa.in_valid = 0;
        drain;
        rand_rdy = 0;
        ifa.out_ready = 1;

        ifa.out_ready = 0;
        ifa.in_valid = 1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            ifa.x = W'($urandom);
            ifa.y = W'($urandom);
            ifa.mode = 1'($urandom);
            @(negedge clk);
            if (ifa.in_ready) begin
                push(ifa.x, ifa.y, ifa.mode);
                acc++;
            end
            step;
        end
        check("stall_accepted", acc, S);
        @(negedge clk);
        check("stall_in_ready", 32'(ifa.in_ready), 0);
        step;
        ifa.in_valid = 0;
        ifa.out_ready = 1;
        drain;

        ifa.out_ready = 0;
        send_a(8'd255, 8'd255, 1'b1);
        send_a(8'd99, 8'd77, 1'b1);
        ifa.in_valid = 0;
        rst_n = 0;
        @(negedge clk);
        check("rst_mid_in_ready", 32'(ifa.in_ready), 0);
        step;
        rst_n = 1;
        ifa.out_ready = 1;
        @(negedge clk);
        check("rst_flush_valid", 32'(ifa.out_valid), 0);
        check("rst_flush_err", err_a, 0);
        repeat (5) step;
        send_a(8'd200, 8'd100, 1'b1);
        ifa.in_valid = 0;
        drain;

        ifb.in_valid = 1; ifb.x = 15; ifb.y = 15; ifb.mode = 1;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifb.in_ready) nb++;
            step;
        end
        ifb.in_valid = 0;
        check("b_accepted", nb, 5);
        repeat (4) step;
        @(negedge clk);
        check("b_saturated", 32'(err_b), 3);
        step;
        clr_b = 1;
        step;
        clr_b = 0;
        @(negedge clk);
        check("b_clear", 32'(err_b), 0);
        step;
        ifb.in_valid = 1;
        step;
        ifb.in_valid = 0;
        step;
        clr_b = 1;
        @(negedge clk);
        check("b_out_valid", 32'(ifb.out_valid), 1);
        step;
        clr_b = 0;
        @(negedge clk);
        check("b_clear_wins", 32'(err_b), 0);
        step;
        ifb.in_valid = 1;
        step;
        ifb.in_valid = 0;
        repeat (3) step;
        @(negedge clk);
        check("b_increment", 32'(err_b), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
